// File: rtl/tdc_sample_ctrl.sv
// Delay-line TDC sequencer: launches an edge, captures the thermometer code,
// averages 2^avg_log2 popcounts and flags bubbles seen in any sample.
module tdc_sample_ctrl #(
    parameter int unsigned N_TAPS       = 16,
    parameter int unsigned AVG_MAX_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        avg_log2,
    input  logic [3:0]        settle,
    input  logic [N_TAPS-1:0] taps,
    output logic              launch,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        result,
    output logic              err
);

    localparam int unsigned PW = 7;
    localparam int unsigned AW = PW + AVG_MAX_LOG2;
    localparam int unsigned CW = AVG_MAX_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, HIGH, CAPT, ACC, LOW, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        avg_q, avg_d;
    logic [3:0]        s_q, s_d;
    logic [3:0]        tmr_q, tmr_d;
    logic [N_TAPS-1:0] cap_q, cap_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              bub_q, bub_d;
    logic              launch_q, launch_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [7:0]        result_q, result_d;
    logic              err_q, err_d;

    function automatic logic [PW-1:0] popcount(input logic [N_TAPS-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < N_TAPS; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    // A set tap above a clear tap breaks the thermometer code
    function automatic logic has_bubble(input logic [N_TAPS-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 1; i < N_TAPS; i++) b = b | (v[i] & ~v[i-1]);
        return b;
    endfunction

    always_comb begin
        state_d  = state_q;
        avg_d    = avg_q;
        s_d      = s_q;
        tmr_d    = tmr_q;
        cap_d    = cap_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        bub_d    = bub_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    avg_d   = (32'(avg_log2) > AVG_MAX_LOG2) ? 3'(AVG_MAX_LOG2) : avg_log2;
                    s_d     = (settle == 4'd0) ? 4'd1 : settle;
                    tmr_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    bub_d   = 1'b0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tmr_q == s_q - 4'd1) begin
                    tmr_d   = '0;
                    state_d = CAPT;
                end else begin
                    tmr_d = tmr_q + 4'd1;
                end
            end
            CAPT: begin
                cap_d   = taps;
                state_d = ACC;
            end
            ACC: begin
                acc_d = acc_q + AW'(popcount(cap_q));
                bub_d = bub_q | has_bubble(cap_q);
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == (CW'(1) << avg_q)) begin
                    result_d = 8'(acc_d >> avg_q);
                    err_d    = bub_d;
                    state_d  = DONE;
                end else begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tmr_q == s_q - 4'd1) begin
                    tmr_d   = '0;
                    state_d = HIGH;
                end else begin
                    tmr_d = tmr_q + 4'd1;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        launch_d = (state_d == HIGH) || (state_d == CAPT);
        busy_d   = (state_d != IDLE);
        valid_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            avg_q    <= '0;
            s_q      <= 4'd1;
            tmr_q    <= '0;
            cap_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            bub_q    <= 1'b0;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            avg_q    <= avg_d;
            s_q      <= s_d;
            tmr_q    <= tmr_d;
            cap_q    <= cap_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            bub_q    <= bub_d;
            launch_q <= launch_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign launch    = launch_q;
    assign busy      = busy_q;
    assign res_valid = valid_q;
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tdc_sample_ctrl.sv
// Directed bench for tdc_sample_ctrl: vector table of measurements plus
// hand sequences for handshake stall and mid-measurement reset.
module tb_tdc_sample_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  avg_log2;
    logic [3:0]  settle;
    logic [15:0] taps;
    logic        launch;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  result;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  avg;
        logic [3:0]  settle;
        logic [15:0] t0, t1, t2, t3;
        int          exp_res;
        int          exp_err;
        int          n;
        int          s;
    } vec_t;

    vec_t vecs[$];

    tdc_sample_ctrl #(.N_TAPS(16), .AVG_MAX_LOG2(4)) dut (
        .clk(clk), .rst(rst), .start(start), .avg_log2(avg_log2),
        .settle(settle), .taps(taps), .launch(launch), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] a, input logic [3:0] st,
                           input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] t2, input logic [15:0] t3,
                           input int r, input int e, input int n, input int s);
        vec_t v;
        v.avg = a; v.settle = st; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
        v.exp_res = r; v.exp_err = e; v.n = n; v.s = s;
        vecs.push_back(v);
    endtask

    // Runs one measurement up to the first res_valid cycle and checks it
    task automatic measure(input vec_t v, input string tag);
        logic [15:0] tv [4];
        int edges, pulses, hi, idx;
        logic prev;
        bit done;
        tv[0] = v.t0; tv[1] = v.t1; tv[2] = v.t2; tv[3] = v.t3;
        avg_log2 = v.avg; settle = v.settle; taps = tv[0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        avg_log2 = 3'd5; settle = 4'd9;
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        edges = 0; pulses = 0; hi = 0; prev = 1'b0; done = 1'b0;
        while (!done && edges < 2000) begin
            if (launch) begin
                hi++;
                if (!prev) begin
                    pulses++;
                    idx = (pulses > 4) ? 3 : pulses - 1;
                    taps = tv[idx];
                end
            end
            prev = launch;
            if (res_valid) done = 1'b1;
            else begin
                @(posedge clk); #1;
                edges++;
            end
        end
        chk({tag, "_done_in_budget"}, int'(done), 1);
        chk({tag, "_latency"}, edges, v.n * (2 * v.s + 2) - v.s);
        chk({tag, "_pulses"}, pulses, v.n);
        chk({tag, "_launch_high"}, hi, v.n * (v.s + 1));
        chk({tag, "_result"}, int'(result), v.exp_res);
        chk({tag, "_err"}, int'(err), v.exp_err);
        chk({tag, "_busy_done"}, int'(busy), 1);
    endtask

    task automatic handshake(input string tag, input int exp_res, input int exp_err);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, int'(res_valid), 0);
        chk({tag, "_busy_idle"}, int'(busy), 0);
        taps = 16'h1234;
        @(posedge clk); #1;
        chk({tag, "_result_hold"}, int'(result), exp_res);
        chk({tag, "_err_hold"}, int'(err), exp_err);
    endtask

    initial begin
        vec_t v;
        int pulses;
        logic prev;
        rst = 1'b1; start = 1'b0; avg_log2 = '0; settle = '0; taps = '0; res_ready = 1'b0;

        add_vec(3'd0, 4'd2, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 8, 0, 1, 2);
        add_vec(3'd2, 4'd1, 16'h000F, 16'h001F, 16'h003F, 16'h007F, 5, 0, 4, 1);
        add_vec(3'd0, 4'd1, 16'h00F7, 16'h00F7, 16'h00F7, 16'h00F7, 7, 1, 1, 1);
        add_vec(3'd0, 4'd1, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 2, 0, 1, 1);
        add_vec(3'd7, 4'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16, 0, 16, 1);
        add_vec(3'd1, 4'd3, 16'h0001, 16'h0010, 16'h0010, 16'h0010, 1, 1, 2, 3);
        add_vec(3'd3, 4'd15, 16'hFFFF, 16'h7FFF, 16'h3FFF, 16'h1FFF, 13, 0, 8, 15);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_launch", int'(launch), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(res_valid), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_err", int'(err), 0);

        foreach (vecs[i]) begin
            measure(vecs[i], $sformatf("v%0d", i));
            handshake($sformatf("v%0d", i), vecs[i].exp_res, vecs[i].exp_err);
        end

        // Stalled consumer: outputs hold and start is ignored in DONE
        measure(vecs[0], "stall");
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            taps  = 16'hFFFF;
            @(posedge clk); #1;
            chk($sformatf("stall_valid_%0d", c), int'(res_valid), 1);
            chk($sformatf("stall_result_%0d", c), int'(result), 8);
            chk($sformatf("stall_err_%0d", c), int'(err), 0);
        end
        start = 1'b0;
        handshake("stall", 8, 0);
        @(posedge clk); #1;
        chk("stall_no_restart", int'(busy), 0);

        // Reset during HIGH of the second sample
        v = vecs[1];
        avg_log2 = v.avg; settle = 4'd2; taps = 16'h00FF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; prev = 1'b0;
        for (int c = 0; c < 100 && pulses < 2; c++) begin
            if (launch && !prev) pulses++;
            prev = launch;
            if (pulses < 2) begin
                @(posedge clk); #1;
            end
        end
        chk("rst_reached_sample2", pulses, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_launch", int'(launch), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_err", int'(err), 0);
        measure(v, "post_rst");
        handshake("post_rst", v.exp_res, v.exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
